fnd_decoder: RTL and testbench
==============================

Name: fnd_decoder

Overview:
- Receive side of the multiplexed 4-digit FND interface: watches the scanned fndCom/fndFont bus and rebuilds the 14-bit decimal value (0-9999) being displayed.
- Uses: loopback self-check of FndController on the board, and a scoreboard tap in benches.
- Samples each digit after it has been stable for a settle time, decodes active-low segment codes, and assembles a full frame.
- Converts the four BCD digits to binary and emits a one-cycle valid pulse per completed frame.

Parameters:
- STABLE_CYCLES, 16, consecutive cycles fndCom/fndFont must hold unchanged before a digit is sampled (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset is synchronous and active-high.
- fndCom  input  4  digit commons, active-low one-hot; bit0 = ones, bit3 = thousands.
- fndFont  input  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
- number  output  14  last successfully decoded value, binary 0-9999.
- number_valid  output  1  one-cycle pulse when number updates.
- dp  output  4  dp state (1 = lit) per digit from the last valid frame.
- font_err  output  1  one-cycle pulse: sampled digit had an illegal segment code.
- com_err  output  1  one-cycle pulse: more than one fndCom bit low at sample time.

Behaviour:
- Reset values: number=0, dp=0, number_valid=0, font_err=0, com_err=0, frame mask=0, settle counter=0, state=COLLECT.
- Input stage: fndCom and fndFont are registered once. All timing below counts from the registered copy.
- Settle counter:
  - Clears whenever the registered {fndCom,fndFont} differs from the previous cycle's value.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A sample event fires exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES-1 with inputs unchanged.
- fndCom classification at a sample event:
  - 4'b1111 (blanking): ignored, no error.
  - Exactly one bit low: digit index = position of the low bit.
  - Two or more bits low: com_err pulse, frame mask cleared.
- Font decode on bits6:0 (dp ignored):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
  - 7'h7F (blank) decodes to 0, which supports leading-zero blanking.
  - Any other code: font_err pulse, frame mask cleared, digit not stored.
- Valid sample: digit value and ~fndFont[7] are stored into that digit's slot, and the corresponding mask bit is set.
  - Re-sampling a digit already in the mask overwrites its slot; the mask is unchanged.
- State machine:
  - COLLECT: when the mask becomes 4'b1111, latch the four digits and go to CONVERT. The mask clears in the same cycle.
  - CONVERT (1 cycle): compute d3*1000 + d2*100 + d1*10 + d0 using shift-add constant multiplies (no generic multiplier). Register the result into number and dp, pulse number_valid, return to COLLECT.
- Latency: number_valid asserts exactly 2 clk edges after the sample event that completes the mask. number holds until the next valid frame.
- Identical consecutive frames each produce a number_valid pulse.
- Digit order within a frame is irrelevant; any scan order works.
- A sample event arriving during CONVERT is processed normally into the freshly cleared mask. No sample is lost.
- An error in the same cycle as frame completion cannot occur, because each sample event is single. On an error, the partial frame is discarded and number is not updated.
- Reset asserted mid-frame or during CONVERT: all state returns to reset values on the next edge, and no number_valid is emitted.
- Inputs changing faster than STABLE_CYCLES (ghosting) never generate a sample event.

Decomposition:
- Package fnd_pkg:
  - typedef bcd_t (logic [3:0]).
  - Segment code constants SEG_0..SEG_9 and SEG_BLANK, shared with FndController so encoder and decoder cannot drift.
  - state enum {COLLECT, CONVERT}.
- Sub-module fnd_seg_decode (combinational): seg[6:0] -> {legal, bcd_t}.

Test Plan:
- Scan a 4 ms-style pattern for 1234 with dwell = 20 cycles in order d0..d3, dp off -> one number_valid, number=14'd1234, dp=4'b0000, 2 cycles after the d3 sample.
- Value 7 shown with digits 3..1 blank (7'h7F) -> number=7, no font_err.
- Drive the d2 font 7'h55 during a 9876 frame -> font_err pulse, no number_valid for that frame. The next clean frame gives number=9876.
- Pulse fndCom=4'b0011 stable for 20 cycles -> com_err pulse, mask cleared, number unchanged.
- Toggle fndCom every 8 cycles (< STABLE_CYCLES=16) -> no sample events, no number_valid, no errors.
- Assert reset during the d2 dwell of 5555 -> number=0, mask cleared. After reset, a complete frame gives number=5555 exactly once.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit FND interface: segment codes, BCD type,
// decoder state encoding and the BCD-to-binary helper.
package fnd_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {COLLECT, CONVERT} state_t;

  // Active-low segment codes, bits 6:0 = g..a; FndController encodes with the same table
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Constant multiplies as shift-add: 1000 = 1024-16-8, 100 = 64+32+4, 10 = 8+2
  function automatic logic [13:0] bcd_to_bin(input bcd_t d3, input bcd_t d2,
                                             input bcd_t d1, input bcd_t d0);
    logic [13:0] w3, w2, w1, w0;
    w3 = {10'd0, d3};
    w2 = {10'd0, d2};
    w1 = {10'd0, d1};
    w0 = {10'd0, d0};
    return ((w3 << 10) - (w3 << 4) - (w3 << 3))
         + ((w2 << 6) + (w2 << 5) + (w2 << 2))
         + ((w1 << 3) + (w1 << 1))
         + w0;
  endfunction

endpackage

// File: rtl/fnd_seg_decode.sv
// Combinational active-low 7-segment decoder; blank decodes to a legal zero
// so leading-zero blanking reads back as the displayed value.
module fnd_seg_decode
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output bcd_t       bcd
);

  always_comb begin
    legal = 1'b1;
    bcd   = 4'd0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: bcd = 4'd0;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_decoder.sv
// Rebuilds the displayed 0-9999 value from a scanned fndCom/fndFont bus:
// settle filter, per-digit capture into a frame, then BCD-to-binary conversion.
module fnd_decoder
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  fndCom,
  input  logic [7:0]  fndFont,
  output logic [13:0] number,
  output logic        number_valid,
  output logic [3:0]  dp,
  output logic        font_err,
  output logic        com_err
);

  localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [3:0]       com_q, com_prev;
  logic [7:0]       font_q, font_prev;
  logic [7:0]       settle_cnt;
  logic [3:0]       frame_mask;
  bcd_t [3:0]       digit_slot, conv_digit;
  logic [3:0]       dp_slot, conv_dp;
  state_t           state;

  logic             seg_legal;
  bcd_t             seg_bcd;
  logic             inputs_changed, sample_evt, com_blank, com_single;
  logic [1:0]       digit_idx;
  logic             store_evt, frame_done;
  logic [3:0]       next_mask, next_dp;
  bcd_t [3:0]       next_digit;

  fnd_seg_decode u_seg_decode (
    .seg   (font_q[6:0]),
    .legal (seg_legal),
    .bcd   (seg_bcd)
  );

  always_comb begin
    inputs_changed = {com_q, font_q} != {com_prev, font_prev};
    sample_evt     = !inputs_changed && (settle_cnt == STABLE_LAST);
    com_blank      = (com_q == 4'b1111);
    com_single     = 1'b1;
    digit_idx      = 2'd0;
    case (com_q)
      4'b1110: digit_idx = 2'd0;
      4'b1101: digit_idx = 2'd1;
      4'b1011: digit_idx = 2'd2;
      4'b0111: digit_idx = 2'd3;
      default: com_single = 1'b0;
    endcase
    store_evt  = sample_evt && com_single && seg_legal;
    next_digit = digit_slot;
    next_dp    = dp_slot;
    next_mask  = frame_mask;
    if (store_evt) begin
      next_digit[digit_idx] = seg_bcd;
      next_dp[digit_idx]    = ~font_q[7];
      next_mask[digit_idx]  = 1'b1;
    end
    // Completion is seen on the sampling cycle itself, keeping latency at two edges
    frame_done = store_evt && (next_mask == 4'b1111);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      com_q        <= 4'b1111;
      font_q       <= 8'hFF;
      com_prev     <= 4'b1111;
      font_prev    <= 8'hFF;
      settle_cnt   <= 8'd0;
      frame_mask   <= 4'b0000;
      digit_slot   <= '0;
      dp_slot      <= 4'b0000;
      conv_digit   <= '0;
      conv_dp      <= 4'b0000;
      state        <= COLLECT;
      number       <= 14'd0;
      dp           <= 4'b0000;
      number_valid <= 1'b0;
      font_err     <= 1'b0;
      com_err      <= 1'b0;
    end else begin
      com_q        <= fndCom;
      font_q       <= fndFont;
      com_prev     <= com_q;
      font_prev    <= font_q;
      number_valid <= 1'b0;
      font_err     <= 1'b0;
      com_err      <= 1'b0;

      if (inputs_changed)
        settle_cnt <= 8'd0;
      else if (settle_cnt != STABLE_MAX)
        settle_cnt <= settle_cnt + 8'd1;

      if (sample_evt && !com_blank) begin
        if (!com_single) begin
          com_err    <= 1'b1;
          frame_mask <= 4'b0000;
        end else if (!seg_legal) begin
          font_err   <= 1'b1;
          frame_mask <= 4'b0000;
        end else begin
          digit_slot <= next_digit;
          dp_slot    <= next_dp;
          frame_mask <= frame_done ? 4'b0000 : next_mask;
        end
      end

      case (state)
        COLLECT: begin
          if (frame_done) begin
            conv_digit <= next_digit;
            conv_dp    <= next_dp;
            state      <= CONVERT;
          end
        end
        CONVERT: begin
          number       <= bcd_to_bin(conv_digit[3], conv_digit[2],
                                     conv_digit[1], conv_digit[0]);
          dp           <= conv_dp;
          number_valid <= 1'b1;
          state        <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_decoder.sv
// Directed bench for fnd_decoder: scans hand-built frames onto the FND bus and
// checks decoded value, dp, error pulses and latency against hand-computed values.
module tb_fnd_decoder;

  logic        clk;
  logic        reset;
  logic [3:0]  fndCom;
  logic [7:0]  fndFont;
  logic [13:0] number;
  logic        number_valid;
  logic [3:0]  dp;
  logic        font_err;
  logic        com_err;

  int tests_run = 0;
  int tests_failed = 0;
  int valid_cnt = 0;
  int font_err_cnt = 0;
  int com_err_cnt = 0;

  logic [6:0] seg7 [10];

  fnd_decoder #(.STABLE_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .fndCom       (fndCom),
    .fndFont      (fndFont),
    .number       (number),
    .number_valid (number_valid),
    .dp           (dp),
    .font_err     (font_err),
    .com_err      (com_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses last one full cycle, so counting on the falling edge sees each once
  always @(negedge clk) begin
    if (number_valid) valid_cnt++;
    if (font_err) font_err_cnt++;
    if (com_err) com_err_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic show_digit(input logic [3:0] com, input logic [7:0] font, input int cycles);
    fndCom  = com;
    fndFont = font;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] font_of(input int digit, input logic dp_on);
    return {~dp_on, seg7[digit]};
  endfunction

  task automatic show_frame(input int d3, input int d2, input int d1, input int d0,
                            input logic [3:0] dp_on);
    show_digit(4'b1110, font_of(d0, dp_on[0]), 20);
    show_digit(4'b1101, font_of(d1, dp_on[1]), 20);
    show_digit(4'b1011, font_of(d2, dp_on[2]), 20);
    show_digit(4'b0111, font_of(d3, dp_on[3]), 20);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    show_digit(4'b1111, 8'hFF, 3);
    tests_run++;
    if (number !== 14'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_number: got %0d expected 0", number);
    end
    tests_run++;
    if (dp !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_dp: got %b expected 0000", dp);
    end
    tests_run++;
    if (number_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", number_valid);
    end
    tests_run++;
    if ({font_err, com_err} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_errs: got %b expected 00", {font_err, com_err});
    end
    reset = 1'b0;
    show_digit(4'b1111, 8'hFF, 2);
  endtask

  task automatic test_1234();
    int v0, first;
    v0 = valid_cnt;
    first = -1;
    show_digit(4'b1110, font_of(4, 1'b0), 20);
    show_digit(4'b1101, font_of(3, 1'b0), 20);
    show_digit(4'b1011, font_of(2, 1'b0), 20);
    fndCom  = 4'b0111;
    fndFont = font_of(1, 1'b0);
    // Register stage + 16-cycle settle puts the sample at edge 17, valid 2 edges later
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (number_valid && first < 0) first = k;
    end
    tests_run++;
    if (first !== 19) begin
      tests_failed++;
      $display("[TB] FAIL latency_1234: valid at edge %0d expected 19", first);
    end
    tests_run++;
    if (number !== 14'd1234) begin
      tests_failed++;
      $display("[TB] FAIL number_1234: got %0d expected 1234", number);
    end
    tests_run++;
    if (dp !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL dp_1234: got %b expected 0000", dp);
    end
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL valid_count_1234: got %0d expected 1", valid_cnt - v0);
    end
  endtask

  task automatic test_blank_leading();
    int v0, f0;
    v0 = valid_cnt;
    f0 = font_err_cnt;
    show_digit(4'b1110, font_of(7, 1'b0), 20);
    show_digit(4'b1101, 8'hFF, 20);
    show_digit(4'b1011, 8'hFF, 20);
    show_digit(4'b0111, 8'hFF, 20);
    tests_run++;
    if (number !== 14'd7) begin
      tests_failed++;
      $display("[TB] FAIL number_blank7: got %0d expected 7", number);
    end
    tests_run++;
    if (font_err_cnt - f0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL font_err_blank7: got %0d pulses expected 0", font_err_cnt - f0);
    end
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL valid_count_blank7: got %0d expected 1", valid_cnt - v0);
    end
  endtask

  task automatic test_font_err();
    int v0, f0;
    v0 = valid_cnt;
    f0 = font_err_cnt;
    show_digit(4'b1110, font_of(6, 1'b0), 20);
    show_digit(4'b1101, font_of(7, 1'b0), 20);
    show_digit(4'b1011, {1'b1, 7'h55}, 20);
    show_digit(4'b0111, font_of(9, 1'b0), 20);
    tests_run++;
    if (font_err_cnt - f0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL font_err_pulse: got %0d pulses expected 1", font_err_cnt - f0);
    end
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL font_err_no_valid: got %0d expected 0", valid_cnt - v0);
    end
    tests_run++;
    if (number !== 14'd7) begin
      tests_failed++;
      $display("[TB] FAIL font_err_hold: got %0d expected 7", number);
    end
    v0 = valid_cnt;
    show_frame(9, 8, 7, 6, 4'b0010);
    tests_run++;
    if (number !== 14'd9876) begin
      tests_failed++;
      $display("[TB] FAIL number_9876: got %0d expected 9876", number);
    end
    tests_run++;
    if (dp !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL dp_9876: got %b expected 0010", dp);
    end
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL valid_count_9876: got %0d expected 1", valid_cnt - v0);
    end
  endtask

  task automatic test_com_err();
    int v0, c0;
    v0 = valid_cnt;
    c0 = com_err_cnt;
    show_digit(4'b1110, font_of(1, 1'b0), 20);
    show_digit(4'b1101, font_of(1, 1'b0), 20);
    show_digit(4'b0011, font_of(1, 1'b0), 20);
    show_digit(4'b1011, font_of(1, 1'b0), 20);
    show_digit(4'b0111, font_of(1, 1'b0), 20);
    tests_run++;
    if (com_err_cnt - c0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL com_err_pulse: got %0d pulses expected 1", com_err_cnt - c0);
    end
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL com_err_mask_cleared: got %0d valids expected 0", valid_cnt - v0);
    end
    tests_run++;
    if (number !== 14'd9876) begin
      tests_failed++;
      $display("[TB] FAIL com_err_hold: got %0d expected 9876", number);
    end
    show_digit(4'b1110, font_of(1, 1'b0), 20);
    show_digit(4'b1101, font_of(1, 1'b0), 20);
    tests_run++;
    if (number !== 14'd1111 || valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL number_1111: got %0d (%0d valids) expected 1111 (1 valid)",
               number, valid_cnt - v0);
    end
  endtask

  task automatic test_ghosting();
    int v0, f0, c0;
    v0 = valid_cnt;
    f0 = font_err_cnt;
    c0 = com_err_cnt;
    // Every toggled pattern would raise an error if it were ever sampled
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) show_digit(4'b1110, {1'b1, 7'h55}, 8);
      else            show_digit(4'b0011, font_of(8, 1'b0), 8);
    end
    show_digit(4'b1111, 8'hFF, 20);
    tests_run++;
    if (valid_cnt - v0 !== 0 || font_err_cnt - f0 !== 0 || com_err_cnt - c0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL ghosting: got valid=%0d font_err=%0d com_err=%0d expected all 0",
               valid_cnt - v0, font_err_cnt - f0, com_err_cnt - c0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    v0 = valid_cnt;
    show_digit(4'b1110, font_of(5, 1'b0), 20);
    show_digit(4'b1101, font_of(5, 1'b0), 20);
    show_digit(4'b1011, font_of(5, 1'b0), 8);
    reset = 1'b1;
    show_digit(4'b1011, font_of(5, 1'b0), 2);
    reset = 1'b0;
    tests_run++;
    if (number !== 14'd0 || dp !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_number: got %0d dp=%b expected 0 dp=0000", number, dp);
    end
    show_digit(4'b1011, font_of(5, 1'b0), 20);
    show_digit(4'b0111, font_of(5, 1'b0), 20);
    tests_run++;
    if (valid_cnt - v0 !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_mask_cleared: got %0d valids expected 0", valid_cnt - v0);
    end
    show_digit(4'b1110, font_of(5, 1'b0), 20);
    show_digit(4'b1101, font_of(5, 1'b0), 20);
    show_digit(4'b1111, 8'hFF, 40);
    tests_run++;
    if (number !== 14'd5555) begin
      tests_failed++;
      $display("[TB] FAIL number_5555: got %0d expected 5555", number);
    end
    tests_run++;
    if (valid_cnt - v0 !== 1) begin
      tests_failed++;
      $display("[TB] FAIL valid_count_5555: got %0d expected 1", valid_cnt - v0);
    end
  endtask

  initial begin
    seg7[0] = 7'h40; seg7[1] = 7'h79; seg7[2] = 7'h24; seg7[3] = 7'h30; seg7[4] = 7'h19;
    seg7[5] = 7'h12; seg7[6] = 7'h02; seg7[7] = 7'h78; seg7[8] = 7'h00; seg7[9] = 7'h10;
    reset   = 1'b1;
    fndCom  = 4'b1111;
    fndFont = 8'hFF;
    @(posedge clk);
    #1;
    test_reset();
    test_1234();
    test_blank_leading();
    test_font_err();
    test_com_err();
    test_ghosting();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
